// File: rtl/signed_bcd_display_if.sv
// Handshake and result bus of the signed BCD display converter.
// The master side issues conversion requests; the slave side (the converter)
// reports progress and holds the display results.
interface signed_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic                  start;
    logic [WIDTH-1:0]      data;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  sign_n;
    logic                  ovf;

    modport master (
        output start, data,
        input  busy, done, bcd, seg, sign_n, ovf
    );

    modport slave (
        input  start, data,
        output busy, done, bcd, seg, sign_n, ovf
    );
endinterface

// File: rtl/signed_bcd_display.sv
// Signed two's-complement to BCD converter with seven-segment output.
// A captured value is converted by a shift-and-add-3 loop, one bit per clock,
// then the display registers (BCD, segments, sign, overflow) load together.
module signed_bcd_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    signed_bcd_display_if.slave  bus
);

    // Number of decimal digits needed to hold 2^w - 1.
    function automatic int dec_digits(input int w);
        logic [63:0] v;
        int          n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end else begin
                v = v;
            end
        end
        return n;
    endfunction

    // Active-low gfedcba pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // The internal BCD register covers the whole input range even when fewer
    // digits are displayed, so overflow can be seen in the upper nibbles.
    localparam int NEED_DIGITS = dec_digits(WIDTH);
    localparam int FULL_DIGITS = (NEED_DIGITS > DIGITS) ? NEED_DIGITS : DIGITS;
    localparam int BW          = 4 * FULL_DIGITS;
    localparam int CNT_W       = $clog2(WIDTH);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t                state_r;
    logic [WIDTH-1:0]      mag_r;
    logic [BW-1:0]         bcd_sh_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  sign_r;
    logic                  guard_r;
    logic                  busy_r;
    logic                  done_r;
    logic [4*DIGITS-1:0]   bcd_r;
    logic [7*DIGITS-1:0]   seg_r;
    logic                  sign_n_r;
    logic                  ovf_r;

    logic [WIDTH-1:0]      mag_in_s;
    logic [BW-1:0]         bcd_adj_s;
    logic                  ovf_s;
    logic                  leading_s;
    logic [7*DIGITS-1:0]   seg_s;

    // Magnitude of the incoming value; the most-negative code maps onto
    // 2^(WIDTH-1) because the result is read back as unsigned.
    always_comb begin
        if (bus.data[WIDTH-1]) begin
            mag_in_s = ~bus.data + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_in_s = bus.data;
        end
    end

    // Add-3 correction of every BCD nibble that would exceed 9 after the shift.
    always_comb begin
        bcd_adj_s = bcd_sh_r;
        for (int i = 0; i < FULL_DIGITS; i++) begin
            if (bcd_sh_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_sh_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_sh_r[4*i +: 4];
            end
        end
    end

    // Overflow detection and segment decode with optional leading-zero blanking.
    always_comb begin
        ovf_s     = guard_r;
        leading_s = 1'b1;
        seg_s     = {(7*DIGITS){1'b1}};
        for (int i = DIGITS; i < FULL_DIGITS; i++) begin
            if (bcd_sh_r[4*i +: 4] != 4'd0) begin
                ovf_s = 1'b1;
            end else begin
                ovf_s = ovf_s;
            end
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_s) begin
                seg_s[7*i +: 7] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && leading_s && (i != 0) &&
                         (bcd_sh_r[4*i +: 4] == 4'd0)) begin
                seg_s[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_s[7*i +: 7] = seg7(bcd_sh_r[4*i +: 4]);
                leading_s       = 1'b0;
            end
        end
    end

    // Conversion FSM with registered status and display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            mag_r    <= '0;
            bcd_sh_r <= '0;
            cnt_r    <= '0;
            sign_r   <= 1'b0;
            guard_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            bcd_r    <= '0;
            seg_r    <= {(7*DIGITS){1'b1}};
            sign_n_r <= 1'b1;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        mag_r    <= mag_in_s;
                        sign_r   <= bus.data[WIDTH-1] && (mag_in_s != '0);
                        bcd_sh_r <= '0;
                        cnt_r    <= '0;
                        guard_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= CONV;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                CONV: begin
                    // A bit falling off the top means the value cannot be shown.
                    guard_r  <= guard_r | bcd_adj_s[BW-1];
                    bcd_sh_r <= {bcd_adj_s[BW-2:0], mag_r[WIDTH-1]};
                    mag_r    <= {mag_r[WIDTH-2:0], 1'b0};
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= CONV;
                    end
                end
                LOAD: begin
                    bcd_r    <= bcd_sh_r[4*DIGITS-1:0];
                    seg_r    <= seg_s;
                    sign_n_r <= ~sign_r;
                    ovf_r    <= ovf_s;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.bcd    = bcd_r;
    assign bus.seg    = seg_r;
    assign bus.sign_n = sign_n_r;
    assign bus.ovf    = ovf_r;

endmodule
